// File: rtl/tetris_move_scheduler.sv
// Move-command scheduler between debounced buttons and the Tetris game FSM.
// Optional soft drop (quarter gravity period while DOWN is held) under `SOFT_DROP_EN.
module tetris_move_scheduler #(
    parameter int GRAV_DIV_INIT = 100,
    parameter int GRAV_STEP     = 8,
    parameter int GRAV_DIV_MIN  = 10,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       hold,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_rr,
    input  logic       btn_rl,
    input  logic       btn_down,
    input  logic [3:0] level,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       cmd_gravity,
    input  logic       cmd_ready,
    output logic       grav_overrun,
    output logic       dbg_state
);

    // Handshake: a command transfers on any cycle where cmd_valid & cmd_ready are
    // both high at the rising clock edge; cmd/cmd_gravity never change while
    // cmd_valid is high and not yet accepted (only en low may withdraw it).

    localparam int PW = CNT_W + 4;
    localparam logic signed [PW-1:0] INIT_S = PW'(GRAV_DIV_INIT);
    localparam logic signed [PW-1:0] STEP_S = PW'(GRAV_STEP);
    localparam logic signed [PW-1:0] MIN_S  = PW'(GRAV_DIV_MIN);

    localparam logic [2:0] CMD_RIGHT = 3'd0;
    localparam logic [2:0] CMD_LEFT  = 3'd1;
    localparam logic [2:0] CMD_ROR   = 3'd2;
    localparam logic [2:0] CMD_ROL   = 3'd3;
    localparam logic [2:0] CMD_DOWN  = 3'd4;
    localparam logic [2:0] CMD_NONE  = 3'd7;

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [4:0]       btn_q, btn_d;
    logic [5:0]       pend_q, pend_d;
    logic [5:0]       grant_q, grant_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             grav_q, grav_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;

    logic [4:0]       btn_now;
    logic [4:0]       btn_edge;
    logic [5:0]       pend_set;
    logic [5:0]       pend_clr;
    logic [5:0]       win_oh;
    logic [2:0]       win_cmd;
    logic             win_grav;
    logic             tick;
    logic signed [PW-1:0] lvl_ext;
    logic signed [PW-1:0] period_raw;
    logic signed [PW-1:0] period_lvl;
    logic signed [PW-1:0] period_eff;
    logic signed [PW-1:0] cnt_ext;

    // Button order {rl, rr, right, left, down}; pend bit 0 is gravity.
    assign btn_now  = {btn_rl, btn_rr, btn_right, btn_left, btn_down};
    assign btn_edge = btn_now & ~btn_q;
    assign btn_d    = btn_now;

    always_comb begin
        lvl_ext    = {{(PW-4){1'b0}}, level};
        period_raw = INIT_S - lvl_ext * STEP_S;
        period_lvl = (period_raw < MIN_S) ? MIN_S : period_raw;
`ifdef SOFT_DROP_EN
        if (btn_down && en) begin
            period_eff = ((period_lvl >>> 2) < MIN_S) ? MIN_S : (period_lvl >>> 2);
        end else begin
            period_eff = period_lvl;
        end
`else
        period_eff = period_lvl;
`endif
        cnt_ext = {4'b0000, cnt_q};
        tick    = en && !hold && (cnt_ext >= period_eff - 1);
    end

    // Fixed priority: gravity > down > left > right > ror > rol.
    always_comb begin
        win_oh   = 6'b000000;
        win_cmd  = CMD_NONE;
        win_grav = 1'b0;
        if (pend_q[0]) begin
            win_oh = 6'b000001; win_cmd = CMD_DOWN; win_grav = 1'b1;
        end else if (pend_q[1]) begin
            win_oh = 6'b000010; win_cmd = CMD_DOWN;
        end else if (pend_q[2]) begin
            win_oh = 6'b000100; win_cmd = CMD_LEFT;
        end else if (pend_q[3]) begin
            win_oh = 6'b001000; win_cmd = CMD_RIGHT;
        end else if (pend_q[4]) begin
            win_oh = 6'b010000; win_cmd = CMD_ROR;
        end else if (pend_q[5]) begin
            win_oh = 6'b100000; win_cmd = CMD_ROL;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        grav_d   = grav_q;
        grant_d  = grant_q;
        pend_clr = 6'b000000;
        case (state_q)
            IDLE: begin
                if (en && !hold && (|pend_q)) begin
                    cmd_d   = win_cmd;
                    grav_d  = win_grav;
                    grant_d = win_oh;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    pend_clr = grant_q;
                    cmd_d    = CMD_NONE;
                    grav_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d  = IDLE;
            cmd_d    = CMD_NONE;
            grav_d   = 1'b0;
            grant_d  = 6'b000000;
        end
    end

    // Set beats clear so a press landing on its own grant cycle is kept.
    always_comb begin
        pend_set = {btn_edge, tick};
        pend_d   = en ? ((pend_q & ~pend_clr) | pend_set) : 6'b000000;
        cnt_d    = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        ovr_d = ovr_q | (tick & pend_q[0] & ~pend_clr[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            btn_q   <= '0;
            pend_q  <= '0;
            grant_q <= '0;
            cmd_q   <= CMD_NONE;
            grav_q  <= 1'b0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            cmd_q   <= cmd_d;
            grav_q  <= grav_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cmd_valid    = (state_q == ISSUE);
    assign cmd          = cmd_q;
    assign cmd_gravity  = grav_q;
    assign grav_overrun = ovr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Directed bench for tetris_move_scheduler with an expected-command queue.
// Soft-drop section is compiled only when SOFT_DROP_EN is defined.
module tb_tetris_move_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       hold = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_rr = 1'b0;
    logic       btn_rl = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] level = 4'd0;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_gravity;
    logic       cmd_ready = 1'b0;
    logic       grav_overrun;
    logic       dbg_state;

    tetris_move_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .hold         (hold),
        .btn_right    (btn_right),
        .btn_left     (btn_left),
        .btn_rr       (btn_rr),
        .btn_rl       (btn_rl),
        .btn_down     (btn_down),
        .level        (level),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .cmd_gravity  (cmd_gravity),
        .cmd_ready    (cmd_ready),
        .grav_overrun (grav_overrun),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Expected commands as {cmd_gravity, cmd}.
    logic [3:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         t = 0;
    int         hs_count = 0;
    int         hs_t = 0;
    int         hs_prev = 0;
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [3:0] prev_cmd = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, t);
        end
    endtask

    // Sample at the falling edge, then advance past the next rising edge.
    task automatic cyc();
        logic [3:0] e;
        @(negedge clk);
        if (cmd_valid && prev_valid && !prev_hs)
            check("cmd_stable", {28'd0, cmd_gravity, cmd}, {28'd0, prev_cmd});
        if (!cmd_valid)
            check("idle_cmd", {29'd0, cmd}, 32'd7);
        prev_valid = cmd_valid;
        prev_cmd   = {cmd_gravity, cmd};
        prev_hs    = cmd_valid && cmd_ready;
        if (cmd_valid && cmd_ready) begin
            hs_count++;
            hs_t = t;
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", {28'd0, cmd_gravity, cmd}, 32'hFF);
            end else begin
                e = exp_q.pop_front();
                check("cmd", {28'd0, cmd_gravity, cmd}, {28'd0, e});
            end
        end
        @(posedge clk);
        t++;
        #1;
    endtask

    task automatic run_to(input int target);
        while (t < target) cyc();
    endtask

    task automatic wait_hs(input int budget, input string tag);
        int  start;
        bit  seen;
        start = hs_count;
        seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cyc();
            if (hs_count != start) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $error("FAIL %s: no handshake within %0d cycles, expected one", tag, budget);
        end
    endtask

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        t = 0;
        prev_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        check("rst_valid", cmd_valid, 0);
        check("rst_cmd", cmd, 7);
        check("rst_grav", cmd_gravity, 0);
        check("rst_ovr", grav_overrun, 0);
        check("rst_state", dbg_state, 0);

        // Gravity at level 0: first issue after edge 101, then every 100
        en = 1'b1; cmd_ready = 1'b1; level = 4'd0;
        do_reset();
        exp_q.push_back(4'b1100);
        wait_hs(150, "grav1_timeout");
        check("grav1_time", hs_t, 101);
        exp_q.push_back(4'b1100);
        wait_hs(150, "grav2_timeout");
        check("grav2_time", hs_t, 201);
        check("grav_no_ovr", grav_overrun, 0);

        // Single-cycle LEFT pulse, then a long hold yielding one LEFT
        do_reset();
        run_to(3);
        btn_left = 1'b1;
        cyc();
        btn_left = 1'b0;
        exp_q.push_back(4'b0001);
        begin
            int n;
            n = t;
            wait_hs(10, "left_timeout");
            check("left_time", hs_t, n + 1);
        end
        check("left_one_cycle", cmd_valid, 0);
        run_to(10);
        hs_prev = hs_count;
        exp_q.push_back(4'b0001);
        btn_left = 1'b1;
        repeat (50) cyc();
        btn_left = 1'b0;
        repeat (3) cyc();
        check("left_hold_count", hs_count - hs_prev, 1);

        // RIGHT and ROL together: RIGHT first, ROL two cycles later
        run_to(65);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0011);
        btn_right = 1'b1; btn_rl = 1'b1;
        cyc();
        btn_right = 1'b0; btn_rl = 1'b0;
        begin
            int n;
            n = t;
            hs_prev = hs_count;
            wait_hs(10, "right_timeout");
            check("right_time", hs_t, n + 1);
            wait_hs(10, "rol_timeout");
            check("rol_time", hs_t, n + 3);
        end
        repeat (5) cyc();
        check("pair_count", hs_count - hs_prev, 2);

        // Stalled FSM: gravity held stable, second tick sets overrun
        cmd_ready = 1'b0;
        do_reset();
        run_to(150);
        check("stall_valid", cmd_valid, 1);
        check("stall_cmd", cmd, 4);
        check("stall_grav", cmd_gravity, 1);
        check("stall_ovr0", grav_overrun, 0);
        run_to(160);
        btn_left = 1'b1;
        cyc();
        btn_left = 1'b0;
        run_to(199);
        check("ovr_before_tick2", grav_overrun, 0);
        run_to(201);
        check("ovr_after_tick2", grav_overrun, 1);
        run_to(250);
        check("stall_cmd_late", {cmd_gravity, cmd}, 4'b1100);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0001);
        cmd_ready = 1'b1;
        wait_hs(5, "drain1_timeout");
        check("drain1_time", hs_t, 250);
        wait_hs(5, "drain2_timeout");
        check("drain2_time", hs_t, 252);
        check("ovr_sticky", grav_overrun, 1);

        // Level 15: 10-cycle period; hold freezes the counter
        level = 4'd15;
        do_reset();
        check("ovr_cleared_by_rst", grav_overrun, 0);
        exp_q.push_back(4'b1100);
        wait_hs(20, "l15_t1_timeout");
        check("l15_t1", hs_t, 11);
        exp_q.push_back(4'b1100);
        wait_hs(20, "l15_t2_timeout");
        check("l15_t2", hs_t, 21);
        run_to(24);
        hs_prev = hs_count;
        hold = 1'b1;
        repeat (30) cyc();
        hold = 1'b0;
        check("hold_no_ticks", hs_count - hs_prev, 0);
        exp_q.push_back(4'b1100);
        wait_hs(20, "l15_t3_timeout");
        check("l15_resume", hs_t, 61);

        // en low aborts an in-flight command and flushes pending state
        level = 4'd0; cmd_ready = 1'b0;
        do_reset();
        btn_right = 1'b1;
        cyc();
        btn_right = 1'b0;
        run_to(5);
        check("abort_pre_valid", cmd_valid, 1);
        check("abort_pre_cmd", cmd, 0);
        btn_left = 1'b1;
        en = 1'b0;
        cyc();
        check("abort_valid", cmd_valid, 0);
        check("abort_cmd", cmd, 7);
        check("abort_state", dbg_state, 0);
        run_to(10);
        en = 1'b1; cmd_ready = 1'b1;
        hs_prev = hs_count;
        run_to(30);
        btn_left = 1'b0;
        check("flush_no_cmds", hs_count - hs_prev, 0);
        exp_q.push_back(4'b1100);
        wait_hs(120, "regrav_timeout");
        check("regrav_time", hs_t, 111);

`ifdef SOFT_DROP_EN
        // Soft drop: one player DOWN, then gravity every 25 cycles
        btn_down = 1'b1;
        do_reset();
        exp_q.push_back(4'b0100);
        wait_hs(10, "soft_down_timeout");
        check("soft_down_time", hs_t, 2);
        exp_q.push_back(4'b1100);
        wait_hs(40, "soft_g1_timeout");
        check("soft_g1_time", hs_t, 26);
        exp_q.push_back(4'b1100);
        wait_hs(40, "soft_g2_timeout");
        check("soft_g2_time", hs_t, 51);
        btn_down = 1'b0;
`endif

        repeat (3) cyc();
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tetris_move_scheduler.md
Name: tetris_move_scheduler

Overview:
- Sits between the push-button inputs and the Tetris game FSM.
- Edge-detects player move requests, generates the gravity drop tick, and arbitrates all pending moves onto one move-command channel.
- Issues one command at a time over a valid/ready handshake, so the FSM never sees two moves in one piece-update cycle.
- Gravity period shortens with game level.

Parameters:
- GRAV_DIV_INIT, 100: clk cycles per gravity drop at level 0 (1 s at 100 Hz).
- GRAV_STEP, 8: cycles removed from the period per level.
- GRAV_DIV_MIN, 10: floor on the gravity period.
- CNT_W, 8: width of the gravity counter and period.

Ports:
- clk, input, 1: system clock (hz100).
- rst, input, 1: synchronous active-high reset.
- en, input, 1: game running. Low = scheduler flushed and idle.
- hold, input, 1: FSM busy (spawn/line clear). Blocks new issue and freezes gravity.
- btn_right, input, 1: synchronized button level.
- btn_left, input, 1: synchronized button level.
- btn_rr, input, 1: synchronized button level.
- btn_rl, input, 1: synchronized button level.
- btn_down, input, 1: synchronized button level.
- level, input, 4: current game level.
- cmd_valid, output, 1: command offered.
- cmd, output, 3: move code. RIGHT=0, LEFT=1, ROR=2, ROL=3, DOWN=4, NONE=7.
- cmd_gravity, output, 1: current DOWN comes from gravity, not the player.
- cmd_ready, input, 1: FSM accepts cmd this cycle.
- grav_overrun, output, 1: sticky flag; a gravity tick was lost.

Behaviour:
- Reset values (sync rst):
  - cmd_valid=0, cmd=7, cmd_gravity=0, grav_overrun=0.
  - All pending bits 0, button history 0, gravity counter 0, state IDLE.
- Edge detect: edge_x = btn_x & ~btn_x_q, with btn_x_q registered every cycle.
  - A rising edge sets pend_x at that clock edge.
  - A held button produces a single request.
  - A new edge while pend_x is already set is coalesced.
- Gravity period: period = max(GRAV_DIV_MIN, GRAV_DIV_INIT - level*GRAV_STEP).
  - Computed in CNT_W+4 bits signed-safe; no wrap. Level 15 gives 10.
- Gravity counter:
  - Increments when en & ~hold.
  - At count >= period-1 it returns to 0 and sets pend_grav.
  - If pend_grav is already set at that tick, grav_overrun sets and stays set until rst.
  - A level change mid-count takes effect on the next compare; no counter reset.
- Arbitration, fixed priority: pend_grav (cmd=4, cmd_gravity=1) > pend_down > pend_left > pend_right > pend_rr > pend_rl.
  - Gravity and player DOWN are issued as separate commands.
- State machine:
  - IDLE: cmd_valid=0, cmd=7. If en & ~hold & any pending, latch the winner into cmd/cmd_gravity and go to ISSUE.
  - ISSUE: cmd_valid=1; cmd and cmd_gravity held stable until handshake.
    - On cmd_valid & cmd_ready: clear the granted pending bit and go to IDLE.
    - hold rising during ISSUE does not withdraw the command.
- Throughput: at most one command per 2 cycles.
- Latency: button high first sampled at edge n → pend set after edge n → ISSUE after edge n+1 → cmd_valid during cycle n+2.
- Simultaneous set and clear of the same pend bit: set wins, so a fresh press during its grant is retained.
- en low, any state, next edge:
  - All pend bits cleared, gravity counter to 0, state IDLE, cmd_valid=0.
  - This aborts an in-flight command.
  - Button history still updates, so a button held across en rising does not fire.
  - grav_overrun is unaffected.

Optional Feature:
- SOFT_DROP_EN defined: while btn_down is held and en=1, the effective period is max(GRAV_DIV_MIN, period>>2).
  - Gravity ticks during soft drop still issue with cmd_gravity=1.
  - The btn_down edge still creates one player DOWN.
- SOFT_DROP_EN undefined: btn_down only creates a single DOWN per rising edge; period depends on level only.

Test Plan:
1. rst, en=1, level=0, cmd_ready=1, no buttons → first cmd_valid with cmd=4, cmd_gravity=1 at cycle 101 after rst release; repeats every 100 cycles; grav_overrun=0.
2. Pulse btn_left for 1 cycle at cycle n, cmd_ready=1 → cmd_valid=1, cmd=1, cmd_gravity=0 in cycle n+2 only. Holding btn_left 50 cycles yields exactly one LEFT.
3. btn_right and btn_rl rise in the same cycle, cmd_ready=1 → RIGHT(0) issued, then ROL(3) two cycles later; no other commands.
4. cmd_ready=0 for 250 cycles at level 0 → cmd=4 stays stable with cmd_valid=1. Second gravity tick sets grav_overrun=1. Raise cmd_ready → one DOWN, then the next pending command.
5. level=15 → gravity period 10 cycles. Assert hold for 30 cycles mid-count → no ticks and counter frozen; count resumes from the frozen value after hold drops.
6. Drop en during ISSUE with cmd_ready=0 → cmd_valid=0 and cmd=7 next cycle, all pend bits clear. With SOFT_DROP_EN, level=0, btn_down held → gravity DOWN every 25 cycles.
